cnt_meter: RTL and testbench

CNT_METER -- requirements
Module: cnt_meter

---
 rtl/cnt_meter_pkg.sv | 22 ++
 rtl/cnt_meter.sv | 110 +++++++++++
 tb/tb_cnt_meter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cnt_meter_pkg.sv
// Shared helpers for the cnt_meter period meter.
// The match counter is sized for the largest legal lock threshold (15).
package cnt_meter_pkg;

  localparam int unsigned MCNT_W = 4;

  // Next match count: restart at 1 on a new period, otherwise count up and saturate at lockN.
  function automatic logic [MCNT_W-1:0] nextMatch(
    input logic [MCNT_W-1:0] mcnt,
    input logic              same,
    input logic [MCNT_W-1:0] lockN
  );
    if (!same || (mcnt == '0)) begin
      return MCNT_W'(1);
    end
    if (mcnt >= lockN) begin
      return lockN;
    end
    return mcnt + MCNT_W'(1);
  endfunction

endpackage

// File: rtl/cnt_meter.sv
// Measures the spacing of tick pulses on i in clock cycles and reports lock
// once lock_n consecutive measurements agree; ovf flags a gap too long to measure.
module cnt_meter #(
  parameter int width  = 32,
  parameter int lock_n = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  output logic [width-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             ovf
);
  import cnt_meter_pkg::*;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [width-1:0]  ACC_MAX = '1;
  localparam logic [width-1:0]  ACC_ONE = width'(1);
  localparam logic [MCNT_W-1:0] LOCK_N  = MCNT_W'(lock_n);

  state_t            r_state;
  logic [width-1:0]  r_acc;
  logic [MCNT_W-1:0] r_mcnt;
  logic [width-1:0]  r_period;
  logic              r_valid;
  logic              r_locked;
  logic              r_ovf;

  state_t            w_stateNxt;
  logic [width-1:0]  w_accNxt;
  logic [MCNT_W-1:0] w_mcntNxt;
  logic [width-1:0]  w_periodNxt;
  logic              w_validNxt;
  logic              w_lockedNxt;
  logic              w_ovfNxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcnt   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_acc    <= w_accNxt;
      r_mcnt   <= w_mcntNxt;
      r_period <= w_periodNxt;
      r_valid  <= w_validNxt;
      r_locked <= w_lockedNxt;
      r_ovf    <= w_ovfNxt;
    end
  end

  // acc only reaches ACC_MAX together with ovf, so an event with ovf clear always has a measurable acc.
  always_comb begin
    w_stateNxt  = r_state;
    w_accNxt    = r_acc;
    w_mcntNxt   = r_mcnt;
    w_periodNxt = r_period;
    w_validNxt  = 1'b0;
    w_lockedNxt = r_locked;
    w_ovfNxt    = r_ovf;

    case (r_state)
      IDLE: begin
        if (i) begin
          w_stateNxt = MEAS;
          w_accNxt   = ACC_ONE;
        end
      end
      MEAS: begin
        if (i) begin
          w_accNxt = ACC_ONE;
          if (r_ovf) begin
            w_ovfNxt = 1'b0;
          end else begin
            w_periodNxt = r_acc;
            w_validNxt  = 1'b1;
            w_mcntNxt   = nextMatch(r_mcnt, (r_acc == r_period), LOCK_N);
            w_lockedNxt = (w_mcntNxt == LOCK_N);
          end
        end else if (r_acc != ACC_MAX) begin
          w_accNxt = r_acc + ACC_ONE;
          if (r_acc == (ACC_MAX - ACC_ONE)) begin
            w_ovfNxt    = 1'b1;
            w_lockedNxt = 1'b0;
            w_mcntNxt   = '0;
          end
        end
      end
      default: begin
        w_stateNxt = IDLE;
      end
    endcase
  end

  assign period = r_period;
  assign valid  = r_valid;
  assign locked = r_locked;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_cnt_meter.sv
// Self-checking bench for cnt_meter: an 8-bit instance driven from a table of
// tick segments with a scoreboard of expected valid pulses, and a 4-bit instance for overflow.
module tb_cnt_meter;

  typedef struct {
    int         top;
    int         ticks;
    logic [7:0] expPeriod;
    int         lockAt;
  } segment_t;

  typedef struct {
    logic [7:0] period;
    logic       locked;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i = 1'b0;
  logic [7:0] period;
  logic       valid;
  logic       locked;
  logic       ovf;

  logic       rst4 = 1'b1;
  logic       i4 = 1'b0;
  logic [3:0] period4;
  logic       valid4;
  logic       locked4;
  logic       ovf4;

  int nChecks = 0;
  int nPass = 0;
  exp_t expQ[$];
  segment_t segs[5];

  cnt_meter #(.width(8), .lock_n(4)) dut (
    .clk(clk), .rst(rst), .i(i),
    .period(period), .valid(valid), .locked(locked), .ovf(ovf)
  );

  cnt_meter #(.width(4), .lock_n(4)) dut4 (
    .clk(clk), .rst(rst4), .i(i4),
    .period(period4), .valid(valid4), .locked(locked4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sets the inputs, lets one rising edge sample them, returns 1ns after that edge.
  task automatic applyStimulus(input logic rstV, input logic iV, input logic rst4V, input logic i4V);
    rst  = rstV;
    i    = iV;
    rst4 = rst4V;
    i4   = i4V;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic rstV, input logic iV);
    applyStimulus(rstV, iV, 1'b1, 1'b0);
  endtask

  task automatic drive4(input logic rstV, input logic iV);
    applyStimulus(1'b1, 1'b0, rstV, iV);
  endtask

  // Scoreboard side: every valid pulse of the 8-bit instance must match a queued expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checkOutput("validExpected", (expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("period", period, e.period);
        checkOutput("locked", locked, e.locked);
        checkOutput("ovfOnValid", ovf, 0);
      end
    end
  end

  initial begin
    segs[0] = '{top: 4, ticks: 6, expPeriod: 8'd4, lockAt: 4};
    segs[1] = '{top: 5, ticks: 5, expPeriod: 8'd5, lockAt: 4};
    segs[2] = '{top: 1, ticks: 5, expPeriod: 8'd1, lockAt: 4};
    segs[3] = '{top: 3, ticks: 2, expPeriod: 8'd3, lockAt: 0};
    segs[4] = '{top: 7, ticks: 4, expPeriod: 8'd7, lockAt: 4};

    // Reset held with i high: reset must dominate.
    drive8(1'b1, 1'b1);
    drive8(1'b1, 1'b1);
    checkOutput("rstPeriod", period, 0);
    checkOutput("rstValid", valid, 0);
    checkOutput("rstLocked", locked, 0);
    checkOutput("rstOvf", ovf, 0);

    drive8(1'b0, 1'b0);
    drive8(1'b0, 1'b1);
    checkOutput("armNoValid", valid, 0);

    foreach (segs[s]) begin
      for (int t = 1; t <= segs[s].ticks; t++) begin
        exp_t e;
        repeat (segs[s].top - 1) drive8(1'b0, 1'b0);
        e.period = segs[s].expPeriod;
        e.locked = (segs[s].lockAt != 0) && (t >= segs[s].lockAt);
        expQ.push_back(e);
        drive8(1'b0, 1'b1);
      end
      @(negedge clk);
      #1;
      checkOutput("pendingValids", expQ.size(), 0);
    end

    // Reset two cycles after an event, then re-arm and measure again.
    repeat (3) drive8(1'b0, 1'b0);
    expQ.push_back('{period: 8'd4, locked: 1'b0});
    drive8(1'b0, 1'b1);
    drive8(1'b0, 1'b0);
    drive8(1'b1, 1'b1);
    checkOutput("midRstPeriod", period, 0);
    checkOutput("midRstValid", valid, 0);
    checkOutput("midRstLocked", locked, 0);
    checkOutput("midRstOvf", ovf, 0);
    repeat (3) drive8(1'b0, 1'b0);
    drive8(1'b0, 1'b1);
    checkOutput("rearmNoValid", valid, 0);
    repeat (3) drive8(1'b0, 1'b0);
    expQ.push_back('{period: 8'd4, locked: 1'b0});
    drive8(1'b0, 1'b1);
    repeat (2) drive8(1'b0, 1'b0);
    checkOutput("pendingAfterRst", expQ.size(), 0);

    // 4-bit instance: lock on period 3, then overflow at acc=15.
    drive4(1'b0, 1'b0);
    drive4(1'b0, 1'b1);
    checkOutput("d4ArmNoValid", valid4, 0);
    for (int k = 1; k <= 5; k++) begin
      repeat (2) drive4(1'b0, 1'b0);
      drive4(1'b0, 1'b1);
      checkOutput("d4Valid", valid4, 1);
      checkOutput("d4Period", period4, 3);
      checkOutput("d4Locked", locked4, (k >= 4));
    end
    for (int k = 1; k <= 15; k++) begin
      drive4(1'b0, 1'b0);
      checkOutput("d4Ovf", ovf4, (k >= 14));
      checkOutput("d4LockedOvf", locked4, (k < 14));
      checkOutput("d4NoValid", valid4, 0);
    end
    drive4(1'b0, 1'b1);
    checkOutput("d4OvfCleared", ovf4, 0);
    checkOutput("d4OvfEventNoValid", valid4, 0);
    checkOutput("d4PeriodHeld", period4, 3);

    // Longest measurable period for width 4 is 14.
    repeat (13) drive4(1'b0, 1'b0);
    checkOutput("d4NoOvfAt14", ovf4, 0);
    drive4(1'b0, 1'b1);
    checkOutput("d4MaxValid", valid4, 1);
    checkOutput("d4MaxPeriod", period4, 14);
    checkOutput("d4MaxLocked", locked4, 0);
    checkOutput("d4MaxOvf", ovf4, 0);
    drive4(1'b0, 1'b0);
    checkOutput("d4ValidOneCycle", valid4, 0);
    drive4(1'b0, 1'b0);
    drive4(1'b0, 1'b1);
    checkOutput("d4AfterValid", valid4, 1);
    checkOutput("d4AfterPeriod", period4, 3);
    checkOutput("d4AfterLocked", locked4, 0);

    drive4(1'b0, 1'b0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
